cotm32_trap_ctrl: RTL and testbench
===================================

// Module: cotm32_trap_ctrl
// PURPOSE
//  Machine-mode trap controller: owns MTVEC/MEPC/MCAUSE/MTVAL, executes Zicsr read-modify-writes,
//  sequences trap entry and MRET return. Sits beside the execute stage; takes exception requests
//  and CSR ops from the pipeline, drives flush and PC redirect back to fetch via a valid/ready handshake.
// PARAMETERS
//  RESET_MTVEC   32'h0000_0000   MTVEC value after reset (bits [1:0] forced 0)
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-high
//  trap_req_i       in   1      exception request from pipeline
//  trap_cause_i     in   MXLEN  cause code (trap_cause_t)
//  trap_pc_i        in   32     PC of faulting instruction
//  trap_tval_i      in   32     trap value (bad address / instruction bits / 0)
//  mret_i           in   1      MRET retiring this cycle
//  csr_op_i         in   2      zicsr_csr_op_t; NONE = no access
//  csr_addr_i       in   12     CSR address
//  csr_wdata_i      in   32     operand, already muxed RS1 / zero-extended imm
//  csr_rdata_o      out  32     old CSR value (combinational)
//  csr_illegal_o    out  1      op != NONE to unimplemented address (combinational)
//  stall_o          out  1      controller busy; pipeline must hold
//  flush_o          out  1      squash younger instructions
//  redirect_valid_o out  1      redirect PC valid
//  redirect_pc_o    out  32     redirect target (registered)
//  redirect_ready_i in   1      fetch accepts redirect
// BEHAVIOUR
//  - Clock clk; reset synchronous, active-high on rst.
//  - Reset: state RUN; MTVEC=RESET_MTVEC&~3; MEPC/MCAUSE/MTVAL=0; redirect_pc_o=0; all 1-bit outputs 0.
//  - FSM states RUN, REDIR.
//    RUN: priority trap_req_i > mret_i > CSR op.
//      trap_req_i: at edge MEPC<={trap_pc_i[31:2],2'b00}, MCAUSE<=trap_cause_i, MTVAL<=trap_tval_i,
//        redirect_pc_o<={MTVEC[31:2],2'b00}, ->REDIR. Same-cycle CSR write and mret suppressed.
//      mret_i: redirect_pc_o<=MEPC, ->REDIR; same-cycle CSR write suppressed.
//      CSR op, legal addr: write at edge: RW new=wdata; RS new=old|wdata; RC new=old&~wdata.
//        RS/RC always write (no side effects exist). MTVEC/MEPC bits [1:0] forced 0 on write.
//      Illegal addr: no write; pipeline converts csr_illegal_o into trap_req_i (ILLEGAL_INST) next.
//    REDIR: flush_o=1, redirect_valid_o=1, stall_o=1; redirect_pc_o stable; trap_req_i, mret_i,
//      CSR ops ignored (no state change). redirect_ready_i=1 -> RUN at edge.
//  - Latency: trap_req_i/mret_i sampled cycle N -> redirect_valid_o in N+1; minimum 1 cycle in REDIR.
//  - csr_rdata_o = pre-write value in the same cycle; 0 when illegal or op NONE.
//  - Read of MCAUSE in cycle after trap entry returns new cause (write visible next cycle).
//  - rst mid-REDIR: redirect dropped, returns to reset state.
// CONFIGURATION
//  COTM32_MSCRATCH_EN defined: MSCRATCH (0x340) implemented, full 32-bit RW/RS/RC, reset 0,
//    untouched by trap/MRET. Undefined: 0x340 is illegal (csr_illegal_o=1, no storage).
// STRUCTURE
//  - cotm32_priv_pkg gains: ZICSR_CSR_MSCRATCH=12'h340 in zicsr_csr_addr_t; trap_ctrl_state_t
//    {TRAP_ST_RUN, TRAP_ST_REDIR}.
//  - One sub-module: cotm32_csr_alu (combinational op/old/wdata -> new value). FSM and CSR file stay here.
// TESTING
//  - Reset, MTVEC read via RS wdata=0 -> csr_rdata_o=RESET_MTVEC, no state change.
//  - CSRRW MTVEC<=0x8000_0103 then read -> 0x8000_0100; CSRRS MTVAL 0x0F then CSRRC 0x03 -> 0x0C.
//  - trap_req cause=2, pc=0x100, tval=0xDEAD_BEEF, MTVEC=0x200 -> next cycle redirect_valid=1,
//    pc=0x200, flush=1; MEPC=0x100, MCAUSE=2, MTVAL=0xDEADBEEF.
//  - redirect_ready held 0 for 3 cycles -> redirect held stable, stall=1; CSR op then ignored.
//  - trap_req + mret + CSRRW MTVEC same cycle -> trap taken, MTVEC unchanged; later mret -> pc=MEPC.
//  - CSR 0x340 access: with COTM32_MSCRATCH_EN write/readback 0x1234_5678; without -> csr_illegal_o=1.

Source files
------------

// File: rtl/cotm32_priv_pkg.sv
// Privileged-architecture definitions shared by the machine-mode trap controller.
// Holds the XLEN, the trap cause codes, the Zicsr op/address encodings and the
// trap controller FSM state encoding.
package cotm32_priv_pkg;

   localparam int MXLEN = 32;

   // Machine-mode synchronous exception cause codes
   typedef enum logic [MXLEN-1:0] {
      CAUSE_INST_MISALIGNED  = 32'd0,
      CAUSE_INST_ACCESS      = 32'd1,
      CAUSE_ILLEGAL_INST     = 32'd2,
      CAUSE_BREAKPOINT       = 32'd3,
      CAUSE_LOAD_MISALIGNED  = 32'd4,
      CAUSE_LOAD_ACCESS      = 32'd5,
      CAUSE_STORE_MISALIGNED = 32'd6,
      CAUSE_STORE_ACCESS     = 32'd7,
      CAUSE_ECALL_M          = 32'd11
   } trap_cause_t;

   // Zicsr operation selector; NONE means no CSR access this cycle
   typedef enum logic [1:0] {
      ZICSR_OP_NONE = 2'd0,
      ZICSR_OP_RW   = 2'd1,
      ZICSR_OP_RS   = 2'd2,
      ZICSR_OP_RC   = 2'd3
   } zicsr_csr_op_t;

   // Machine-mode CSR addresses known to the trap controller
   typedef enum logic [11:0] {
      ZICSR_CSR_MTVEC    = 12'h305,
      ZICSR_CSR_MSCRATCH = 12'h340,
      ZICSR_CSR_MEPC     = 12'h341,
      ZICSR_CSR_MCAUSE   = 12'h342,
      ZICSR_CSR_MTVAL    = 12'h343
   } zicsr_csr_addr_t;

   // Trap controller states: normal issue, or holding a PC redirect for fetch
   typedef enum logic [0:0] {
      TRAP_ST_RUN   = 1'b0,
      TRAP_ST_REDIR = 1'b1
   } trap_ctrl_state_t;

   // Clear the two low bits of an address held in MTVEC/MEPC
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cotm32_csr_alu.sv
// Zicsr read-modify-write datapath: computes the new CSR value from the
// operation, the current value and the operand. Purely combinational.
import cotm32_priv_pkg::*;

module cotm32_csr_alu (
   input  logic [1:0]  csr_op,
   input  logic [31:0] old_val,
   input  logic [31:0] wdata,
   output logic [31:0] new_val
);

   // RW replaces, RS sets bits, RC clears bits; NONE leaves the value alone
   always_comb begin
      new_val = old_val;
      case (csr_op)
         ZICSR_OP_RW: new_val = wdata;
         ZICSR_OP_RS: new_val = old_val | wdata;
         ZICSR_OP_RC: new_val = old_val & ~wdata;
         default:     new_val = old_val;
      endcase
   end

endmodule

// File: rtl/cotm32_trap_ctrl.sv
// Machine-mode trap controller: owns MTVEC/MEPC/MCAUSE/MTVAL, executes Zicsr
// read-modify-writes, sequences trap entry and MRET return, and hands a PC
// redirect to fetch over a valid/ready handshake.
// Optional feature macro: COTM32_MSCRATCH_EN adds the MSCRATCH register (0x340);
// without it that address decodes as illegal.
import cotm32_priv_pkg::*;

module cotm32_trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trap_req_i,
   input  logic [MXLEN-1:0] trap_cause_i,
   input  logic [31:0]      trap_pc_i,
   input  logic [31:0]      trap_tval_i,
   input  logic             mret_i,
   input  logic [1:0]       csr_op_i,
   input  logic [11:0]      csr_addr_i,
   input  logic [31:0]      csr_wdata_i,
   output logic [31:0]      csr_rdata_o,
   output logic             csr_illegal_o,
   output logic             stall_o,
   output logic             flush_o,
   output logic             redirect_valid_o,
   output logic [31:0]      redirect_pc_o,
   input  logic             redirect_ready_i
);

   localparam logic [0:0] ST_RUN   = TRAP_ST_RUN;
   localparam logic [0:0] ST_REDIR = TRAP_ST_REDIR;

   logic [0:0]       state;
   logic [31:0]      mtvec;
   logic [31:0]      mepc;
   logic [MXLEN-1:0] mcause;
   logic [31:0]      mtval;
`ifdef COTM32_MSCRATCH_EN
   logic [31:0]      mscratch;
`endif

   logic        sel_mtvec;
   logic        sel_mscratch;
   logic        sel_mepc;
   logic        sel_mcause;
   logic        sel_mtval;
   logic        addr_ok;
   logic        csr_access;
   logic        csr_we;
   logic [31:0] old_val;
   logic [31:0] new_val;

   // Address decode, old-value mux and write qualification
   always_comb begin
      sel_mtvec    = (csr_addr_i == ZICSR_CSR_MTVEC);
`ifdef COTM32_MSCRATCH_EN
      sel_mscratch = (csr_addr_i == ZICSR_CSR_MSCRATCH);
`else
      sel_mscratch = 1'b0;
`endif
      sel_mepc     = (csr_addr_i == ZICSR_CSR_MEPC);
      sel_mcause   = (csr_addr_i == ZICSR_CSR_MCAUSE);
      sel_mtval    = (csr_addr_i == ZICSR_CSR_MTVAL);
      addr_ok      = sel_mtvec | sel_mscratch | sel_mepc | sel_mcause | sel_mtval;
      csr_access   = (csr_op_i != ZICSR_OP_NONE);

      old_val = 32'h0;
      if (sel_mtvec)  old_val = mtvec;
      if (sel_mepc)   old_val = mepc;
      if (sel_mcause) old_val = mcause;
      if (sel_mtval)  old_val = mtval;
`ifdef COTM32_MSCRATCH_EN
      if (sel_mscratch) old_val = mscratch;
`endif

      // Trap entry and MRET both take precedence over a same-cycle CSR write
      csr_we = (state == ST_RUN) && csr_access && addr_ok && !trap_req_i && !mret_i;
   end

   cotm32_csr_alu u_csr_alu (
      .csr_op  (csr_op_i),
      .old_val (old_val),
      .wdata   (csr_wdata_i),
      .new_val (new_val)
   );

   // CSR read port and handshake outputs
   always_comb begin
      csr_rdata_o      = (csr_access && addr_ok) ? old_val : 32'h0;
      csr_illegal_o    = csr_access && !addr_ok;
      redirect_valid_o = (state == ST_REDIR);
      flush_o          = (state == ST_REDIR);
      stall_o          = (state == ST_REDIR);
   end

   // FSM, CSR file and redirect target register
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_RUN;
         mtvec         <= word_align(RESET_MTVEC);
         mepc          <= 32'h0;
         mcause        <= '0;
         mtval         <= 32'h0;
         redirect_pc_o <= 32'h0;
`ifdef COTM32_MSCRATCH_EN
         mscratch      <= 32'h0;
`endif
      end else begin
         case (state)
            ST_RUN: begin
               if (trap_req_i) begin
                  mepc          <= word_align(trap_pc_i);
                  mcause        <= trap_cause_i;
                  mtval         <= trap_tval_i;
                  redirect_pc_o <= word_align(mtvec);
                  state         <= ST_REDIR;
               end else if (mret_i) begin
                  redirect_pc_o <= mepc;
                  state         <= ST_REDIR;
               end else if (csr_we) begin
                  if (sel_mtvec)  mtvec  <= word_align(new_val);
                  if (sel_mepc)   mepc   <= word_align(new_val);
                  if (sel_mcause) mcause <= new_val;
                  if (sel_mtval)  mtval  <= new_val;
`ifdef COTM32_MSCRATCH_EN
                  if (sel_mscratch) mscratch <= new_val;
`endif
               end
            end
            ST_REDIR: begin
               // Hold the redirect until fetch takes it; everything else is ignored
               if (redirect_ready_i) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_cotm32_trap_ctrl.sv
// Directed testbench for cotm32_trap_ctrl: CSR ops, trap entry, redirect
// back-pressure, priority of trap over MRET/CSR, MRET return, illegal CSR
// addresses, optional MSCRATCH and reset during a redirect.
`timescale 1ns/1ps

module tb_cotm32_trap_ctrl;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_RW   = 2'd1;
   localparam logic [1:0] OP_RS   = 2'd2;
   localparam logic [1:0] OP_RC   = 2'd3;

   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;

   logic        clk = 1'b0;
   logic        rst;
   logic        trap_req;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;
   logic        mret;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   int n_chk = 0;
   int n_bad = 0;

   cotm32_trap_ctrl #(.RESET_MTVEC(32'h0000_0043)) dut (
      .clk              (clk),
      .rst              (rst),
      .trap_req_i       (trap_req),
      .trap_cause_i     (trap_cause),
      .trap_pc_i        (trap_pc),
      .trap_tval_i      (trap_tval),
      .mret_i           (mret),
      .csr_op_i         (csr_op),
      .csr_addr_i       (csr_addr),
      .csr_wdata_i      (csr_wdata),
      .csr_rdata_o      (csr_rdata),
      .csr_illegal_o    (csr_illegal),
      .stall_o          (stall),
      .flush_o          (flush),
      .redirect_valid_o (redirect_valid),
      .redirect_pc_o    (redirect_pc),
      .redirect_ready_i (redirect_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      trap_req = 1'b0; mret = 1'b0; csr_op = OP_NONE;
      csr_addr = 12'h0; csr_wdata = 32'h0;
   endtask

   // Non-modifying read (RS with zero operand), checked combinationally
   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csr_op = OP_RS; csr_addr = addr; csr_wdata = 32'h0;
      #1;
      chk(tag, csr_rdata, exp);
      csr_op = OP_NONE;
   endtask

   // One CSR op applied over a clock edge; checks the returned old value
   task automatic csr(input string tag, input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_old);
      csr_op = op; csr_addr = addr; csr_wdata = wd;
      #1;
      chk(tag, csr_rdata, exp_old);
      step();
      csr_op = OP_NONE;
   endtask

   initial begin
      rst = 1'b1; redirect_ready = 1'b0;
      trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
      idle();
      step(); step();
      chk("rst_valid", {31'b0, redirect_valid}, 32'h0);
      chk("rst_flush", {31'b0, flush}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_rpc", redirect_pc, 32'h0);
      rst = 1'b0;
      step();

      // Reset values; RESET_MTVEC low bits masked off
      rd("rst_mtvec", A_MTVEC, 32'h0000_0040);
      step();
      rd("rst_mtvec2", A_MTVEC, 32'h0000_0040);
      rd("rst_mepc", A_MEPC, 32'h0);
      rd("rst_mcause", A_MCAUSE, 32'h0);
      rd("rst_mtval", A_MTVAL, 32'h0);
      csr_op = OP_NONE; csr_addr = A_MTVEC; #1;
      chk("none_rdata", csr_rdata, 32'h0);

      // CSRRW MTVEC, low bits forced to zero
      csr("rw_mtvec_old", OP_RW, A_MTVEC, 32'h8000_0103, 32'h0000_0040);
      rd("rw_mtvec_rd", A_MTVEC, 32'h8000_0100);
      // CSRRS then CSRRC on MTVAL
      csr("rs_mtval_old", OP_RS, A_MTVAL, 32'h0000_000F, 32'h0);
      csr("rc_mtval_old", OP_RC, A_MTVAL, 32'h0000_0003, 32'h0000_000F);
      rd("rc_mtval_rd", A_MTVAL, 32'h0000_000C);

      // Trap entry
      csr("rw_mtvec2", OP_RW, A_MTVEC, 32'h0000_0200, 32'h8000_0100);
      trap_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h100; trap_tval = 32'hDEAD_BEEF;
      step();
      trap_req = 1'b0;
      chk("trap_valid", {31'b0, redirect_valid}, 32'h1);
      chk("trap_rpc", redirect_pc, 32'h0000_0200);
      chk("trap_flush", {31'b0, flush}, 32'h1);
      rd("trap_mcause_next", A_MCAUSE, 32'd2);

      // Back-pressure: redirect held 3 cycles; CSR write and new trap ignored
      for (int i = 0; i < 3; i++) begin
         csr_op = OP_RW; csr_addr = A_MEPC; csr_wdata = 32'hFFFF_FFFF;
         trap_req = 1'b1; trap_cause = 32'd7; trap_pc = 32'h999; mret = 1'b1;
         step();
         chk("hold_valid", {31'b0, redirect_valid}, 32'h1);
         chk("hold_stall", {31'b0, stall}, 32'h1);
         chk("hold_rpc", redirect_pc, 32'h0000_0200);
      end
      idle();
      redirect_ready = 1'b1;
      step();
      chk("accept_valid", {31'b0, redirect_valid}, 32'h0);
      chk("accept_stall", {31'b0, stall}, 32'h0);
      rd("trap_mepc", A_MEPC, 32'h100);
      rd("trap_mcause", A_MCAUSE, 32'd2);
      rd("trap_mtval", A_MTVAL, 32'hDEAD_BEEF);

      // Trap + MRET + CSRRW MTVEC in one cycle: trap wins, MTVEC untouched
      trap_req = 1'b1; mret = 1'b1; trap_cause = 32'd11; trap_pc = 32'h307; trap_tval = 32'h0;
      csr_op = OP_RW; csr_addr = A_MTVEC; csr_wdata = 32'h0000_0400;
      step();
      idle();
      chk("prio_valid", {31'b0, redirect_valid}, 32'h1);
      chk("prio_rpc", redirect_pc, 32'h0000_0200);
      step();
      chk("prio_back", {31'b0, redirect_valid}, 32'h0);
      rd("prio_mtvec", A_MTVEC, 32'h0000_0200);
      rd("prio_mepc", A_MEPC, 32'h0000_0304);
      rd("prio_mcause", A_MCAUSE, 32'd11);

      // MRET with a same-cycle CSR write that must be dropped
      mret = 1'b1; csr_op = OP_RW; csr_addr = A_MTVAL; csr_wdata = 32'h55;
      step();
      idle();
      chk("mret_valid", {31'b0, redirect_valid}, 32'h1);
      chk("mret_rpc", redirect_pc, 32'h0000_0304);
      step();
      rd("mret_mtval", A_MTVAL, 32'h0);

      // Unimplemented address
      csr_op = OP_RW; csr_addr = 12'h7C0; csr_wdata = 32'h1; #1;
      chk("ill_flag", {31'b0, csr_illegal}, 32'h1);
      chk("ill_rdata", csr_rdata, 32'h0);
      csr_op = OP_NONE; #1;
      chk("ill_none", {31'b0, csr_illegal}, 32'h0);

      // MSCRATCH
`ifdef COTM32_MSCRATCH_EN
      csr("mscr_old", OP_RW, A_MSCRATCH, 32'h1234_5678, 32'h0);
      rd("mscr_rd", A_MSCRATCH, 32'h1234_5678);
      chk("mscr_legal", {31'b0, csr_illegal}, 32'h0);
`else
      csr_op = OP_RW; csr_addr = A_MSCRATCH; csr_wdata = 32'h1234_5678; #1;
      chk("mscr_ill", {31'b0, csr_illegal}, 32'h1);
      chk("mscr_rdata", csr_rdata, 32'h0);
      csr_op = OP_NONE;
`endif

      // Reset while a redirect is pending
      redirect_ready = 1'b0;
      trap_req = 1'b1; trap_cause = 32'd5; trap_pc = 32'h440; trap_tval = 32'h1;
      step();
      idle();
      chk("rr_valid", {31'b0, redirect_valid}, 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rr_drop", {31'b0, redirect_valid}, 32'h0);
      chk("rr_rpc", redirect_pc, 32'h0);
      rd("rr_mtvec", A_MTVEC, 32'h0000_0040);
      rd("rr_mcause", A_MCAUSE, 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
